// File: rtl/sync_fifo_ctrl_if.sv
// rtl/sync_fifo_ctrl_if.sv - push/pop, status and error signals of one FIFO port
interface sync_fifo_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              flush;
  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;
  logic              err_clr;

  modport master (
    output flush, push, data_in, pop, err_clr,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, push, data_in, pop, err_clr,
    output data_out, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - synchronous FIFO with show-ahead or registered read,
// occupancy thresholds, flush and sticky overflow/underflow flags
module sync_fifo_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sync_fifo_ctrl_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_AF   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] LVL_AE   = (ADDR_W+1)'(AE_THRESH);

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sync_fifo_ctrl: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sync_fifo_ctrl: AF_THRESH out of range 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sync_fifo_ctrl: AE_THRESH out of range 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_q;
  logic              ovf_q;
  logic              udf_q;

  logic full_w;
  logic empty_w;
  logic push_ok;
  logic pop_ok;
  logic ovf_set;
  logic udf_set;

  // Accept decisions look only at registered occupancy, so a same-cycle pop
  // never makes room for a push and a same-cycle push never feeds a pop.
  assign full_w  = (level_q == LVL_FULL);
  assign empty_w = (level_q == '0);
  assign push_ok = bus.push && !full_w  && !bus.flush;
  assign pop_ok  = bus.pop  && !empty_w && !bus.flush;
  assign ovf_set = bus.push && full_w   && !bus.flush;
  assign udf_set = bus.pop  && empty_w  && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + (ADDR_W+1)'(1);
        2'b01:   level_q <= level_q - (ADDR_W+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= bus.data_in;
  end

  // A fresh error in the same cycle as err_clr must survive the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)          ovf_q <= 1'b1;
      else if (bus.err_clr) ovf_q <= 1'b0;
      if (udf_set)          udf_q <= 1'b1;
      else if (bus.err_clr) udf_q <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.data_out = mem[rd_ptr];
      assign bus.rd_valid = !empty_w;
    end else begin : g_reg
      logic [DATA_W-1:0] dout_q;
      logic              rv_q;

      // pop_ok already excludes flush, so a flush drops rd_valid and keeps data_out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else begin
          rv_q <= pop_ok;
          if (pop_ok) dout_q <= mem[rd_ptr];
        end
      end

      assign bus.data_out = dout_q;
      assign bus.rd_valid = rv_q;
    end
  endgenerate

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (level_q >= LVL_AF);
  assign bus.almost_empty = (level_q <= LVL_AE);
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

  // Pointer distance modulo DEPTH always equals occupancy modulo DEPTH.
  a_level_range : assert property (@(posedge clk) disable iff (!rst_n)
    level_q <= LVL_FULL);
  a_ptr_level : assert property (@(posedge clk) disable iff (!rst_n)
    (wr_ptr - rd_ptr) == level_q[ADDR_W-1:0]);
endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised synchronous FIFO for switch ingress/egress queues, the next generation of the per-port packet buffer. Data width and depth are configurable, and the block provides two selectable read modes: show-ahead and registered-read. It adds programmable almost-full/almost-empty thresholds, an occupancy output, synchronous flush, and sticky overflow/underflow error flags for the port status logic.

Parameters:
DATA_W, 32, width of each stored word (bits)
DEPTH, 16, number of entries; power of two, >= 2 (elaboration error otherwise)
AF_THRESH, 12, almost_full asserts when level >= AF_THRESH; range 1..DEPTH
AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH; range 0..DEPTH-1
FWFT, 1, 1 = show-ahead read; 0 = registered read with one-cycle latency
ADDR_W (localparam), $clog2(DEPTH), pointer width

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of contents
push  in  1  write request
data_in  in  DATA_W  write data
pop  in  1  read request
data_out  out  DATA_W  read data
rd_valid  out  1  data_out qualifier
full  out  1  level == DEPTH
empty  out  1  level == 0
almost_full  out  1  level >= AF_THRESH
almost_empty  out  1  level <= AE_THRESH
level  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (async, rst_n=0): wr_ptr=rd_ptr=0, level=0, overflow=underflow=0, rd_valid=0, registered data_out=0. Outputs: empty=1, full=0, almost_empty=1, almost_full=0. Memory is not reset.
- Push is accepted iff push && !full && !flush. A pop in the same cycle does not free space for the push. On accept: mem[wr_ptr] <= data_in, wr_ptr++.
- Pop is accepted iff pop && !empty && !flush. A push in the same cycle does not supply data for the pop. On accept: rd_ptr++.
- Pointers are ADDR_W bits and wrap naturally from DEPTH-1 to 0.
- level update: +1 on push-only accept, -1 on pop-only accept, unchanged when both or neither are accepted.
- full, empty, almost_full and almost_empty are combinational decodes of the registered level.
- FWFT=1 mode:
  - data_out = mem[rd_ptr] (combinational).
  - rd_valid = !empty.
  - Data written into an empty FIFO appears on data_out the cycle after the push edge.
  - data_out is don't-care while empty.
- FWFT=0 mode:
  - On an accepted pop, data_out <= mem[rd_ptr] at that edge, and rd_valid=1 for exactly the following cycle.
  - Back-to-back pops produce back-to-back rd_valid.
  - data_out holds its last value when there is no accepted pop.
  - A rejected pop leaves rd_valid=0.
- flush: highest priority.
  - Next edge: wr_ptr=rd_ptr=0, level=0, rd_valid=0.
  - push and pop in the same cycle are ignored and do not set error flags.
  - overflow/underflow are not cleared by flush.
  - data_out (registered mode) holds its value.
- overflow is set on push && full && !flush. underflow is set on pop && empty && !flush.
- err_clr clears both flags at the next edge. If a set condition and err_clr occur in the same cycle, the set wins.
- Reset mid-operation: immediate return to reset state. Any in-flight registered read is lost (rd_valid=0).

Test Plan:
- DATA_W=8, DEPTH=4, FWFT=1: push 0x11,0x22,0x33,0x44 -> level 1..4, full=1 after 4th edge. Pop 4 -> data_out 0x11,0x22,0x33,0x44 in order, empty=1, level=0.
- Full wrap: fill 4, pop 2, push 0x55,0x66 (wr_ptr wraps to 0,1), pop 4 -> 0x33,0x44,0x55,0x66. A 5th push while full -> overflow=1, level stays 4. err_clr -> overflow=0 next cycle.
- Simultaneous: level=2 with push+pop in the same cycle -> level stays 2, order preserved. At level=0, push+pop -> push accepted, pop rejected, underflow=1, level=1. At level=4, push+pop -> pop accepted, push rejected, overflow=1, level=3.
- FWFT=0: push 0xA1,0xB2, then pop on 2 consecutive cycles -> rd_valid high on the following 2 cycles with data_out 0xA1 then 0xB2. Pop on empty -> rd_valid=0, underflow=1.
- Thresholds AF=3, AE=1: levels 0,1,2,3,4 -> almost_empty 1,1,0,0,0 and almost_full 0,0,0,1,1. flush at level=3 with push=1 -> level=0 next edge, empty=1, no overflow set.
- Assert rst_n=0 asynchronously mid-stream at level=3 with overflow=1 -> all outputs return to reset values before the next clk edge. A subsequent push of 0x77 is read back as 0x77.
